// File: rtl/cr16_pkg.sv
// Shared encodings for the CR16 sequencer: ALU opcodes, instruction fields, Bcond codes, flag indices, FSM states.
// CR16_ILLEGAL_TRAP_EN adds the S_HALT state used by the illegal-instruction trap.
package cr16_pkg;

    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_ADD = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b1001;
    localparam logic [3:0] ALU_CMP = 4'b1011;
    localparam logic [3:0] ALU_MOV = 4'b1101;

    localparam logic [3:0] OP_RR    = 4'b0000;
    localparam logic [3:0] OP_ANDI  = 4'b0001;
    localparam logic [3:0] OP_ORI   = 4'b0010;
    localparam logic [3:0] OP_XORI  = 4'b0011;
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] OP_SUBI  = 4'b1001;
    localparam logic [3:0] OP_CMPI  = 4'b1011;
    localparam logic [3:0] OP_BCOND = 4'b1100;
    localparam logic [3:0] OP_MOVI  = 4'b1101;
    localparam logic [3:0] OP_LUI   = 4'b1111;

    localparam logic [3:0] BC_EQ = 4'b0000;
    localparam logic [3:0] BC_NE = 4'b0001;
    localparam logic [3:0] BC_CS = 4'b0010;
    localparam logic [3:0] BC_CC = 4'b0011;
    localparam logic [3:0] BC_HI = 4'b0100;
    localparam logic [3:0] BC_LS = 4'b0101;
    localparam logic [3:0] BC_GT = 4'b0110;
    localparam logic [3:0] BC_LE = 4'b0111;
    localparam logic [3:0] BC_FS = 4'b1010;
    localparam logic [3:0] BC_FC = 4'b1011;
    localparam logic [3:0] BC_LO = 4'b1100;
    localparam logic [3:0] BC_HS = 4'b1101;
    localparam logic [3:0] BC_UC = 4'b1110;

    localparam int FLAG_C = 0;
    localparam int FLAG_L = 1;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 4;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_DECODE  = 2'd1,
        S_EXECUTE = 2'd2
`ifdef CR16_ILLEGAL_TRAP_EN
        , S_HALT  = 2'd3
`endif
    } state_t;

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

endpackage

// File: rtl/cr16_decoder.sv
// Combinational instruction decoder: IR to ALU op, register selects, immediate and instruction class.
module cr16_decoder
    import cr16_pkg::*;
(
    input  logic [15:0] i_ir,
    output logic [3:0]  o_alu_op,
    output logic [3:0]  o_rdest,
    output logic [3:0]  o_rsrc,
    output logic        o_imm_sel,
    output logic [15:0] o_imm,
    output logic        o_write,
    output logic        o_is_alu,
    output logic        o_is_branch,
    output logic        o_illegal
);

    // Field extraction per instruction format; undefined encodings leave everything inactive
    always_comb begin
        o_alu_op    = 4'b0000;
        o_rdest     = 4'b0000;
        o_rsrc      = 4'b0000;
        o_imm_sel   = 1'b0;
        o_imm       = 16'h0000;
        o_write     = 1'b0;
        o_is_alu    = 1'b0;
        o_is_branch = 1'b0;
        o_illegal   = 1'b0;
        case (i_ir[15:12])
            OP_RR: begin
                case (i_ir[7:4])
                    ALU_ADD, ALU_SUB, ALU_CMP, ALU_AND, ALU_OR, ALU_XOR, ALU_MOV: begin
                        o_alu_op = i_ir[7:4];
                        o_rdest  = i_ir[11:8];
                        o_rsrc   = i_ir[3:0];
                        o_is_alu = 1'b1;
                        o_write  = (i_ir[7:4] != ALU_CMP);
                    end
                    default: o_illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_SUBI, OP_CMPI: begin
                o_alu_op  = i_ir[15:12];
                o_rdest   = i_ir[11:8];
                o_imm_sel = 1'b1;
                o_imm     = sext8(i_ir[7:0]);
                o_is_alu  = 1'b1;
                o_write   = (i_ir[15:12] != OP_CMPI);
            end
            OP_ANDI, OP_ORI, OP_XORI, OP_MOVI: begin
                o_alu_op  = i_ir[15:12];
                o_rdest   = i_ir[11:8];
                o_imm_sel = 1'b1;
                o_imm     = {8'h00, i_ir[7:0]};
                o_is_alu  = 1'b1;
                o_write   = 1'b1;
            end
            OP_LUI: begin
                o_alu_op  = ALU_MOV;
                o_rdest   = i_ir[11:8];
                o_imm_sel = 1'b1;
                o_imm     = {i_ir[7:0], 8'h00};
                o_is_alu  = 1'b1;
                o_write   = 1'b1;
            end
            OP_BCOND: o_is_branch = 1'b1;
            default:  o_illegal   = 1'b1;
        endcase
    end

endmodule

// File: rtl/cr16_controller.sv
// CR16 fetch/decode/execute sequencer owning the PC and evaluating Bcond against datapath flags.
// CR16_ILLEGAL_TRAP_EN: undefined encodings halt the sequencer instead of executing as NOP.
module cr16_controller #(
    parameter logic [15:0] P_RESET_PC = 16'h0000
) (
    input  logic        I_CLK,
    input  logic        I_RESET,
    input  logic        I_ENABLE,
    output logic        O_FETCH_REQ,
    output logic [15:0] O_PC,
    input  logic        I_INSTR_VALID,
    input  logic [15:0] I_INSTR,
    input  logic [4:0]  I_STATUS_FLAGS,
    output logic        O_DP_ENABLE,
    output logic [15:0] O_REG_WRITE_ENABLE,
    output logic [3:0]  O_REG_A_SELECT,
    output logic [3:0]  O_REG_B_SELECT,
    output logic        O_IMMEDIATE_SELECT,
    output logic [15:0] O_IMMEDIATE,
    output logic [3:0]  O_OPCODE,
    output logic        O_ILLEGAL
);
    import cr16_pkg::*;

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_pc;
    logic [15:0] r_ir;
    logic [3:0]  r_opcode;
    logic [3:0]  r_rega;
    logic [3:0]  r_regb;
    logic        r_imm_sel;
    logic [15:0] r_imm;
    logic [15:0] r_we;
    logic        r_dp_en;
    logic        r_take;

    logic [3:0]  w_alu_op;
    logic [3:0]  w_rdest;
    logic [3:0]  w_rsrc;
    logic        w_imm_sel;
    logic [15:0] w_imm;
    logic        w_write;
    logic        w_is_alu;
    logic        w_is_branch;
    logic        w_illegal;
    logic        w_cond_true;

    cr16_decoder u_decoder (
        .i_ir        (r_ir),
        .o_alu_op    (w_alu_op),
        .o_rdest     (w_rdest),
        .o_rsrc      (w_rsrc),
        .o_imm_sel   (w_imm_sel),
        .o_imm       (w_imm),
        .o_write     (w_write),
        .o_is_alu    (w_is_alu),
        .o_is_branch (w_is_branch),
        .o_illegal   (w_illegal)
    );

    // Branch condition from the registered datapath flags
    always_comb begin
        w_cond_true = 1'b0;
        case (r_ir[11:8])
            BC_EQ:   w_cond_true =  I_STATUS_FLAGS[FLAG_Z];
            BC_NE:   w_cond_true = ~I_STATUS_FLAGS[FLAG_Z];
            BC_CS:   w_cond_true =  I_STATUS_FLAGS[FLAG_C];
            BC_CC:   w_cond_true = ~I_STATUS_FLAGS[FLAG_C];
            BC_HI:   w_cond_true =  I_STATUS_FLAGS[FLAG_L];
            BC_LS:   w_cond_true = ~I_STATUS_FLAGS[FLAG_L];
            BC_GT:   w_cond_true =  I_STATUS_FLAGS[FLAG_N];
            BC_LE:   w_cond_true = ~I_STATUS_FLAGS[FLAG_N];
            BC_FS:   w_cond_true =  I_STATUS_FLAGS[FLAG_F];
            BC_FC:   w_cond_true = ~I_STATUS_FLAGS[FLAG_F];
            BC_LO:   w_cond_true = ~I_STATUS_FLAGS[FLAG_L] & ~I_STATUS_FLAGS[FLAG_Z];
            BC_HS:   w_cond_true =  I_STATUS_FLAGS[FLAG_L] |  I_STATUS_FLAGS[FLAG_Z];
            BC_UC:   w_cond_true = 1'b1;
            default: w_cond_true = 1'b0;
        endcase
    end

    // FSM state register; I_ENABLE low freezes the sequencer
    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            r_state <= S_FETCH;
        end else if (I_ENABLE) begin
            r_state <= w_next_state;
        end else begin
            r_state <= r_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH: begin
                if (I_INSTR_VALID) begin
                    w_next_state = S_DECODE;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
`ifdef CR16_ILLEGAL_TRAP_EN
            S_DECODE: begin
                if (w_illegal) begin
                    w_next_state = S_HALT;
                end else begin
                    w_next_state = S_EXECUTE;
                end
            end
            S_HALT:    w_next_state = S_HALT;
`else
            S_DECODE:  w_next_state = S_EXECUTE;
`endif
            S_EXECUTE: w_next_state = S_FETCH;
            default:   w_next_state = S_FETCH;
        endcase
    end

    // PC, instruction register and registered control fields
    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            r_pc      <= P_RESET_PC;
            r_ir      <= 16'h0000;
            r_opcode  <= 4'b0000;
            r_rega    <= 4'b0000;
            r_regb    <= 4'b0000;
            r_imm_sel <= 1'b0;
            r_imm     <= 16'h0000;
            r_we      <= 16'h0000;
            r_dp_en   <= 1'b0;
            r_take    <= 1'b0;
        end else if (I_ENABLE) begin
            case (r_state)
                S_FETCH: begin
                    if (I_INSTR_VALID) begin
                        r_ir <= I_INSTR;
                    end else begin
                        r_ir <= r_ir;
                    end
                end
                S_DECODE: begin
                    r_opcode  <= w_alu_op;
                    r_rega    <= w_rsrc;
                    r_regb    <= w_rdest;
                    r_imm_sel <= w_imm_sel;
                    r_imm     <= w_imm;
                    r_we      <= (w_write & ~w_illegal) ? (16'h0001 << w_rdest) : 16'h0000;
                    r_dp_en   <= w_is_alu & ~w_illegal;
                    r_take    <= w_is_branch & w_cond_true;
                end
                S_EXECUTE: begin
                    r_pc    <= r_take ? (r_pc + sext8(r_ir[7:0])) : (r_pc + 16'h0001);
                    r_we    <= 16'h0000;
                    r_dp_en <= 1'b0;
                    r_take  <= 1'b0;
                end
                default: begin
                    r_pc <= r_pc;
                end
            endcase
        end else begin
            r_pc <= r_pc;
        end
    end

`ifdef CR16_ILLEGAL_TRAP_EN
    logic r_illegal;

    // Sticky trap indication; only reset clears it
    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            r_illegal <= 1'b0;
        end else if (I_ENABLE && (r_state == S_DECODE)) begin
            r_illegal <= w_illegal;
        end else begin
            r_illegal <= r_illegal;
        end
    end

    assign O_ILLEGAL = r_illegal;
`else
    assign O_ILLEGAL = 1'b0;
`endif

    // Request and enables are suppressed while frozen so no grant or write is lost
    assign O_FETCH_REQ        = (r_state == S_FETCH) & I_ENABLE & ~I_RESET;
    assign O_PC               = r_pc;
    assign O_DP_ENABLE        = r_dp_en & I_ENABLE;
    assign O_REG_WRITE_ENABLE = I_ENABLE ? r_we : 16'h0000;
    assign O_REG_A_SELECT     = r_rega;
    assign O_REG_B_SELECT     = r_regb;
    assign O_IMMEDIATE_SELECT = r_imm_sel;
    assign O_IMMEDIATE        = r_imm;
    assign O_OPCODE           = r_opcode;

endmodule
